iter_seq_counter: RTL

Parametrised cycle sequencer for the iterative arithmetic datapath (shift-add multiplier, restoring divider, integer square root). It accepts a start request with a per-operation mode and iteration count, loads the operands, steps the datapath once per clock for the programmed number of iterations, and reports completion. The datapath's feedback mux and the top-level control state machine both sit directly behind this block. It generalises the fixed-length multiplier counter with programmable length, multiple modes, a divider fix-up cycle, abort, and error reporting.

---
 rtl/iter_seq_counter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/iter_seq_counter.sv
// Cycle sequencer for the iterative arithmetic datapath (multiply, divide,
// square root). It walks LOAD -> RUN x L -> [FIXUP] -> DONE and drives the
// datapath strobes from registered state only. It rejects illegal requests
// with a one-cycle err pulse.
module iter_seq_counter #(
  parameter int WORD_LENGTH     = 17,
  parameter int NBitsForCounter = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 mode,
  input  logic [NBitsForCounter-1:0] length,
  output logic                       busy,
  output logic                       load,
  output logic                       flag_mux,
  output logic                       step,
  output logic                       flag_last,
  output logic                       fixup,
  output logic                       done,
  output logic                       err,
  output logic [NBitsForCounter-1:0] count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0]                 MODE_DIV = 2'b01;
  localparam logic [1:0]                 MODE_ILL = 2'b11;
  localparam logic [NBitsForCounter-1:0] ONE      = NBitsForCounter'(1);
  localparam logic [NBitsForCounter-1:0] MAX_LEN  = NBitsForCounter'(WORD_LENGTH);

  state_t                     state_q, state_n;
  logic [NBitsForCounter-1:0] count_q, count_n;
  logic [1:0]                 mode_q, mode_n;
  logic [NBitsForCounter-1:0] len_q, len_n;
  logic                       err_q, err_n;

  logic illegal_req;
  logic last_iter;

  // A request is illegal when its mode is reserved or its length is outside 1..WORD_LENGTH.
  // Rejecting such lengths up front is what keeps the counter from ever wrapping.
  assign illegal_req = (mode == MODE_ILL) || (length == '0) || (length > MAX_LEN);
  assign last_iter   = (count_q == (len_q - ONE));

  // Next-state logic. Abort in any active state returns to IDLE.
  // The DONE cycle itself is still decoded from the current state.
  always_comb begin
    state_n = state_q;
    count_n = count_q;
    mode_n  = mode_q;
    len_n   = len_q;
    err_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mode_n = mode;
          len_n  = length;
          if (illegal_req) begin
            err_n = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        count_n = '0;
        state_n = RUN;
      end
      RUN: begin
        if (last_iter) begin
          count_n = '0;
          state_n = (mode_q == MODE_DIV) ? FIXUP : DONE;
        end else begin
          count_n = count_q + ONE;
        end
      end
      FIXUP: begin
        state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
    if (abort && (state_q != IDLE)) begin
      state_n = IDLE;
      count_n = '0;
    end
  end

  // State, counter, captured request and err pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      mode_q  <= 2'b00;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      mode_q  <= mode_n;
      len_q   <= len_n;
      err_q   <= err_n;
    end
  end

  // Output decode from registered values only, so no input reaches an output combinationally.
  always_comb begin
    busy      = (state_q == LOAD) || (state_q == RUN) || (state_q == FIXUP);
    load      = (state_q == LOAD);
    flag_mux  = (state_q == LOAD);
    step      = (state_q == RUN);
    flag_last = (state_q == RUN) && last_iter;
    fixup     = (state_q == FIXUP);
    done      = (state_q == DONE);
    err       = err_q;
    count     = count_q;
  end

endmodule
